// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and feeder state encoding
package uart_pkg;
  localparam int UART_DW = 8;
  typedef enum logic {IDLE, WAIT} feeder_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with occupancy count and overflow pulse
// Ports: clk, rst (async, active-high); wr_en/wr_data push, rd_en pop,
// rd_data head entry; full, empty, count occupancy; overflow one-cycle drop pulse.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          push, pop;
  // Write acceptance uses the registered full, independent of a same-cycle pop.
  assign push     = wr_en && !full;
  assign pop      = rd_en && !empty;
  assign full     = count_q == (AW+1)'(DEPTH);
  assign empty    = count_q == '0;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_data  = mem_q[rd_ptr_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q  <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_q    <= wr_en && full;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= wr_data;
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: queues bytes and launches them one at a time into the UART serializer
// Ports: clk, rst (async, active-high); wr_en/wr_data byte push; full, empty,
// count, overflow FIFO status; tx_busy/tx_done from serializer;
// start_trig one-cycle launch pulse with registered tx_data.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = UART_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic                   start_trig,
  output logic [DW-1:0]          tx_data
);
  feeder_state_t state_q;
  logic          start_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] head;
  logic          launch;
  // tx_busy in IDLE means the serializer is still finishing its last frame.
  assign launch     = state_q == IDLE && !empty && !tx_busy;
  assign start_trig = start_q;
  assign tx_data    = data_q;
  uart_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (launch),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      data_q  <= '0;
    end else if (state_q == IDLE) begin
      start_q <= launch;
      data_q  <= launch ? head : data_q;
      state_q <= launch ? WAIT : IDLE;
    end else begin
      start_q <= 1'b0;
      state_q <= tx_done ? IDLE : WAIT;
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed vectors plus serializer-model sequences for uart_tx_feeder
module tb_uart_tx_feeder;
  logic       clk = 0, rst = 1, wr_en = 0;
  logic [7:0] wr_data = 0;
  logic       full, empty, overflow, tx_busy, tx_done, start_trig;
  logic [3:0] count;
  logic [7:0] tx_data;
  logic       model_en = 0, hold = 0, v_busy = 0, v_done = 0, m_busy, m_done, chk_gap = 0;
  int         m_cnt, cyc = 0, last_done = -1, checks = 0, passed = 0;
  logic [7:0] launched [$];

  always #5 clk = ~clk;

  assign tx_busy = model_en ? (m_busy | hold) : v_busy;
  assign tx_done = model_en ? m_done : v_done;

  uart_tx_feeder #(.DEPTH(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_busy(tx_busy), .tx_done(tx_done), .start_trig(start_trig), .tx_data(tx_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Serializer model: busy from the cycle after start, done pulse with busy, then idle.
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_cnt <= 0;
    end else if (model_en && start_trig) begin
      m_busy <= 1; m_cnt <= 3;
    end else if (m_busy) begin
      if (m_done) begin m_done <= 0; m_busy <= 0; end
      else if (m_cnt == 1) m_done <= 1;
      m_cnt <= m_cnt - 1;
    end

  always @(negedge clk) begin
    cyc++;
    if (model_en && tx_done) last_done = cyc;
    if (model_en && start_trig) begin
      launched.push_back(tx_data);
      chk("launch_while_busy", tx_busy, 0);
      if (chk_gap && last_done >= 0) chk("launch_gap", cyc - last_done, 2);
    end
  end

  typedef struct {
    logic wr; logic [7:0] d; logic busy, done;
    logic [3:0] cnt; logic emp, ful, ovf, st; logic [7:0] q;
  } vec_t;
  vec_t v [23];

  task automatic pulse_reset();
    rst = 1; wr_en = 0; hold = 0;
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic wait_launches(input int n, input string name);
    int t = 0;
    while (launched.size() < n && t < 300) begin @(posedge clk); t++; end
    if (launched.size() < n) chk({name, "_timeout"}, launched.size(), n);
  endtask

  initial begin
    v[0]  = '{1, 8'hA5, 0, 0, 1, 0, 0, 0, 0, 8'h00};
    v[1]  = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 8'hA5};
    v[2]  = '{0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 8'hA5};
    v[3]  = '{1, 8'h3C, 1, 0, 1, 0, 0, 0, 0, 8'hA5};
    v[4]  = '{0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 8'hA5};
    v[5]  = '{0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'hA5};
    v[6]  = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 8'h3C};
    v[7]  = '{0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h3C};
    v[8]  = '{0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h3C};
    for (int i = 0; i < 8; i++)
      v[9+i] = '{1, 8'(i), 1, 0, 4'(i+1), 0, (i == 7), 0, 0, 8'h3C};
    v[17] = '{1, 8'h08, 1, 0, 8, 0, 1, 1, 0, 8'h3C};
    v[18] = '{0, 8'h00, 1, 0, 8, 0, 1, 0, 0, 8'h3C};
    v[19] = '{1, 8'h09, 0, 0, 7, 0, 0, 1, 1, 8'h00};
    v[20] = '{0, 8'h00, 1, 0, 7, 0, 0, 0, 0, 8'h00};
    v[21] = '{0, 8'h00, 1, 1, 7, 0, 0, 0, 0, 8'h00};
    v[22] = '{0, 8'h00, 0, 0, 6, 0, 0, 0, 1, 8'h01};

    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_count", count, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0); chk("rst_start", start_trig, 0); chk("rst_data", tx_data, 0);

    for (int i = 0; i < 23; i++) begin
      wr_en = v[i].wr; wr_data = v[i].d; v_busy = v[i].busy; v_done = v[i].done;
      @(posedge clk); #1;
      chk($sformatf("v%0d_count", i), count, v[i].cnt);
      chk($sformatf("v%0d_empty", i), empty, v[i].emp);
      chk($sformatf("v%0d_full", i), full, v[i].ful);
      chk($sformatf("v%0d_ovf", i), overflow, v[i].ovf);
      chk($sformatf("v%0d_start", i), start_trig, v[i].st);
      chk($sformatf("v%0d_data", i), tx_data, v[i].q);
    end
    wr_en = 0; v_busy = 0; v_done = 0;
    pulse_reset();
    model_en = 1;

    launched.delete(); chk_gap = 1; last_done = -1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = 8'h11 * 8'(i + 1);
      @(posedge clk); #1;
    end
    wr_en = 0;
    wait_launches(3, "burst");
    repeat (20) @(posedge clk);
    #1 chk_gap = 0;
    chk("burst_n", launched.size(), 3);
    for (int i = 0; i < 3 && i < launched.size(); i++)
      chk($sformatf("burst_b%0d", i), launched[i], 8'h11 * 8'(i + 1));
    chk("burst_empty", empty, 1);

    launched.delete(); hold = 1;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1; wr_data = 8'(i);
      @(posedge clk); #1;
      if (i == 7) chk("ovf_full8", full, 1);
      if (i == 8) begin chk("ovf_pulse", overflow, 1); chk("ovf_count", count, 8); end
    end
    wr_en = 0;
    @(posedge clk); #1 chk("ovf_pulse_end", overflow, 0);
    hold = 0;
    wait_launches(8, "ovf");
    repeat (20) @(posedge clk);
    chk("ovf_n", launched.size(), 8);
    for (int i = 0; i < 8 && i < launched.size(); i++)
      chk($sformatf("ovf_b%0d", i), launched[i], 8'(i));

    #1 launched.delete();
    begin
      int n = 0, t = 0, mx = 0;
      while (n < 20 && t < 2000) begin
        wr_en = count < 3; wr_data = 8'h40 + 8'(n);
        if (wr_en) n++;
        @(posedge clk); #1;
        if (count > mx) mx = count;
        t++;
      end
      wr_en = 0;
      chk("wrap_max_count", mx, 3);
    end
    wait_launches(20, "wrap");
    repeat (10) @(posedge clk);
    chk("wrap_n", launched.size(), 20);
    for (int i = 0; i < 20 && i < launched.size(); i++)
      chk($sformatf("wrap_b%0d", i), launched[i], 8'h40 + 8'(i));

    #1 launched.delete();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 8'h60 + 8'(i);
      @(posedge clk); #1;
    end
    wr_en = 0;
    chk("mid_count4", count, 4);
    chk("mid_busy", tx_busy, 1);
    rst = 1; #1;
    chk("mid_rst_count", count, 0); chk("mid_rst_empty", empty, 1); chk("mid_rst_full", full, 0);
    chk("mid_rst_ovf", overflow, 0); chk("mid_rst_start", start_trig, 0); chk("mid_rst_data", tx_data, 0);
    @(posedge clk); #1 rst = 0;
    repeat (20) @(posedge clk);
    chk("mid_no_relaunch", launched.size(), 1);
    wr_en = 1; wr_data = 8'h77;
    @(posedge clk); #1 wr_en = 0;
    wait_launches(2, "mid_new");
    if (launched.size() > 1) chk("mid_new_byte", launched[1], 8'h77);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
